// File: rtl/write_rr_arbiter.sv
// Round-robin write arbiter driving the channel selecter's enable/select pair, one packet at a time.
// Optional watchdog release of stuck packets when WRITE_ARB_TIMEOUT_EN is defined.
module write_rr_arbiter #(
  parameter int unsigned num_of_ports   = 16,
  parameter int unsigned sel_width      = 4,
  parameter int unsigned timeout_cycles = 64
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [num_of_ports-1:0] req,
  input  logic [num_of_ports-1:0] eop,
  input  logic                    ready,
  output logic                    enable,
  output logic [sel_width-1:0]    select,
  output logic [num_of_ports-1:0] grant,
  output logic                    beat_valid,
  output logic                    timeout_err
);

  if (num_of_ports < 2 || num_of_ports > 16 || (2 ** sel_width) < num_of_ports
      || timeout_cycles < 2) begin : g_bad_cfg
    $error("write_rr_arbiter: illegal parameter combination");
  end

  typedef enum logic [1:0] {IDLE, BUSY, GAP} state_e;

  state_e               state_q, state_d;
  logic                 enable_q, enable_d;
  logic [sel_width-1:0] select_q, select_d;
  logic [sel_width-1:0] last_q, last_d;
  logic                 beat_valid_q, beat_valid_d;
  logic                 timeout_err_q, timeout_err_d;
  logic [sel_width-1:0] winner;
  logic                 beat;

`ifdef WRITE_ARB_TIMEOUT_EN
  localparam int unsigned CNT_W = $clog2(timeout_cycles + 1);
  logic [CNT_W-1:0] cnt_q, cnt_d;
`endif

  // First requester after last_q, wrapping modulo num_of_ports.
  always_comb begin
    int unsigned idx;
    winner = '0;
    idx    = 0;
    for (int i = int'(num_of_ports); i >= 1; i--) begin
      idx = 32'(last_q) + 32'(i);
      if (idx >= num_of_ports) idx = idx - num_of_ports;
      if (req[idx]) winner = sel_width'(idx);
    end
  end

  always_comb begin
    grant = '0;
    if (state_q == BUSY && ready && req[select_q]) grant[select_q] = 1'b1;
  end

  assign beat = |grant;

  always_comb begin
    state_d       = state_q;
    enable_d      = enable_q;
    select_d      = select_q;
    last_d        = last_q;
    beat_valid_d  = beat;
    timeout_err_d = 1'b0;
`ifdef WRITE_ARB_TIMEOUT_EN
    cnt_d         = cnt_q;
`endif
    case (state_q)
      IDLE, GAP: begin
        if (|req) begin
          state_d  = BUSY;
          enable_d = 1'b1;
          select_d = winner;
          last_d   = winner;
`ifdef WRITE_ARB_TIMEOUT_EN
          cnt_d    = '0;
`endif
        end else begin
          state_d  = IDLE;
          enable_d = 1'b0;
          select_d = '0;
        end
      end
      BUSY: begin
`ifdef WRITE_ARB_TIMEOUT_EN
        cnt_d = cnt_q + CNT_W'(1);
`endif
        if (beat && eop[select_q]) begin
          state_d  = GAP;
          enable_d = 1'b0;
        end
`ifdef WRITE_ARB_TIMEOUT_EN
        // Watchdog: this is the timeout_cycles-th BUSY cycle without an eop beat.
        else if (cnt_q == CNT_W'(timeout_cycles - 1)) begin
          state_d       = GAP;
          enable_d      = 1'b0;
          timeout_err_d = 1'b1;
        end
`endif
      end
      default: begin
        state_d  = IDLE;
        enable_d = 1'b0;
        select_d = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q       <= IDLE;
      enable_q      <= 1'b0;
      select_q      <= '0;
      last_q        <= sel_width'(num_of_ports - 1);
      beat_valid_q  <= 1'b0;
      timeout_err_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      enable_q      <= enable_d;
      select_q      <= select_d;
      last_q        <= last_d;
      beat_valid_q  <= beat_valid_d;
      timeout_err_q <= timeout_err_d;
    end
  end

`ifdef WRITE_ARB_TIMEOUT_EN
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) cnt_q <= '0;
    else      cnt_q <= cnt_d;
  end
`endif

  assign enable      = enable_q;
  assign select      = select_q;
  assign beat_valid  = beat_valid_q;
  assign timeout_err = timeout_err_q;

endmodule

// File: tb/tb_write_rr_arbiter.sv
// Randomized bench for write_rr_arbiter against a packet-level model, plus directed scenarios.
module tb_write_rr_arbiter;
  localparam int N  = 16;
  localparam int SW = 4;
  localparam int TO = 8;

  logic          clk;
  logic          rst;
  logic [N-1:0]  req;
  logic [N-1:0]  eop;
  logic          ready;
  logic          enable;
  logic [SW-1:0] select;
  logic [N-1:0]  grant;
  logic          beat_valid;
  logic          timeout_err;

  write_rr_arbiter #(.num_of_ports(N), .sel_width(SW), .timeout_cycles(TO)) dut (
    .clk(clk), .rst(rst), .req(req), .eop(eop), .ready(ready),
    .enable(enable), .select(select), .grant(grant),
    .beat_valid(beat_valid), .timeout_err(timeout_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Model: owner is the port holding a packet, -1 when none (idle or gap).
  int            m_owner, m_last, m_cnt;
  logic          m_en, m_bv, m_to;
  logic [SW-1:0] m_sel;
  int            n_vec, n_bad;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
    end
  endtask

  function automatic int pick(input logic [N-1:0] r, input int last);
    for (int k = 1; k <= N; k++) begin
      int p;
      p = (last + k) % N;
      if (r[p]) return p;
    end
    return -1;
  endfunction

  function automatic logic [N-1:0] m_grant();
    if (m_owner >= 0 && ready && req[m_owner]) return N'(1) << m_owner;
    return '0;
  endfunction

  task automatic model_reset();
    m_owner = -1; m_last = N - 1; m_cnt = 0;
    m_en = 1'b0; m_sel = '0; m_bv = 1'b0; m_to = 1'b0;
  endtask

  task automatic model_step();
    logic [N-1:0] g;
    int w;
    if (!rst) begin
      model_reset();
    end else begin
      g = m_grant();
      m_bv = (g != 0);
      m_to = 1'b0;
      if (m_owner < 0) begin
        w = pick(req, m_last);
        if (w >= 0) begin
          m_owner = w; m_last = w; m_cnt = 0; m_en = 1'b1; m_sel = SW'(w);
        end else begin
          m_en = 1'b0; m_sel = '0;
        end
      end else begin
        m_cnt++;
        if (g != 0 && eop[m_owner]) begin
          m_owner = -1; m_en = 1'b0;
        end
`ifdef WRITE_ARB_TIMEOUT_EN
        else if (m_cnt == TO) begin
          m_owner = -1; m_en = 1'b0; m_to = 1'b1;
        end
`endif
      end
    end
  endtask

  task automatic compare_all();
    chk("enable", 32'(enable), 32'(m_en));
    chk("select", 32'(select), 32'(m_sel));
    chk("grant", 32'(grant), 32'(m_grant()));
    chk("beat_valid", 32'(beat_valid), 32'(m_bv));
    chk("timeout_err", 32'(timeout_err), 32'(m_to));
  endtask

  // One clock: compare on the falling edge, advance the model, return just after the rising edge.
  task automatic tick();
    @(negedge clk);
    compare_all();
    model_step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [N-1:0] r, input logic [N-1:0] e, input logic rd);
    req = r; eop = e; ready = rd;
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b0; req = '0; eop = '0; ready = 1'b0;
    #1;
    model_reset();
    tick();
    rst = 1'b1;
  endtask

  initial begin
    logic [N-1:0] r, e;
    n_vec = 0; n_bad = 0;
    do_reset();
    chk("rst_enable", 32'(enable), 32'd0);
    chk("rst_select", 32'(select), 32'd0);
    chk("rst_bv", 32'(beat_valid), 32'd0);

    // 3-beat packet on port 3
    drive(16'h0008, 16'h0000, 1'b1); tick();
    chk("p3_enable", 32'(enable), 32'd1);
    chk("p3_select", 32'(select), 32'd3);
    drive(16'h0008, 16'h0000, 1'b1); chk("p3_grant1", 32'(grant), 32'h8); tick();
    chk("p3_bv1", 32'(beat_valid), 32'd1);
    drive(16'h0008, 16'h0000, 1'b1); chk("p3_grant2", 32'(grant), 32'h8); tick();
    drive(16'h0008, 16'h0008, 1'b1); chk("p3_grant3", 32'(grant), 32'h8); tick();
    chk("p3_gap_enable", 32'(enable), 32'd0);
    chk("p3_gap_bv", 32'(beat_valid), 32'd1);
    drive(16'h0000, 16'h0000, 1'b1); chk("p3_gap_grant", 32'(grant), 32'h0); tick();
    chk("p3_idle_bv", 32'(beat_valid), 32'd0);
    chk("p3_idle_select", 32'(select), 32'd0);

    // reset asserted mid-packet with select=5
    drive(16'h0020, 16'h0000, 1'b1); tick();
    chk("p5_select", 32'(select), 32'd5);
    drive(16'h0020, 16'h0000, 1'b1); chk("p5_grant", 32'(grant), 32'h20);
    rst = 1'b0; #1;
    chk("midrst_enable", 32'(enable), 32'd0);
    chk("midrst_grant", 32'(grant), 32'd0);
    model_reset();
    tick();
    rst = 1'b1;
    drive(16'h0001, 16'h0000, 1'b1); tick();
    chk("postrst_select", 32'(select), 32'd0);
    chk("postrst_enable", 32'(enable), 32'd1);

    // alternating single-beat packets on ports 0 and 2
    do_reset();
    for (int p = 0; p < 4; p++) begin
      drive(16'h0005, 16'h0005, 1'b1); tick();
      chk("alt_enable", 32'(enable), 32'd1);
      chk("alt_select", 32'(select), (p % 2 == 0) ? 32'd0 : 32'd2);
      drive(16'h0005, 16'h0005, 1'b1); tick();
      chk("alt_gap", 32'(enable), 32'd0);
    end

    // wrap from last=15: port 0 then port 15
    do_reset();
    drive(16'h8001, 16'h8001, 1'b1); tick();
    chk("wrap_first", 32'(select), 32'd0);
    drive(16'h8001, 16'h8001, 1'b1); tick();
    drive(16'h8001, 16'h8001, 1'b1); tick();
    chk("wrap_second", 32'(select), 32'd15);

    // ready stall
    do_reset();
    drive(16'h0010, 16'h0000, 1'b1); tick();
    drive(16'h0010, 16'h0000, 1'b1); tick();
    for (int s = 0; s < 4; s++) begin
      drive(16'h0010, 16'h0000, 1'b0);
      chk("stall_grant", 32'(grant), 32'd0);
      tick();
      chk("stall_enable", 32'(enable), 32'd1);
      chk("stall_select", 32'(select), 32'd4);
    end
    drive(16'h0010, 16'h0010, 1'b1); chk("resume_grant", 32'(grant), 32'h10); tick();

    // packet that never ends
    do_reset();
    drive(16'h0003, 16'h0000, 1'b1); tick();
`ifdef WRITE_ARB_TIMEOUT_EN
    for (int c = 0; c < TO; c++) begin
      drive(16'h0003, 16'h0000, 1'b1); tick();
    end
    chk("to_pulse", 32'(timeout_err), 32'd1);
    chk("to_enable", 32'(enable), 32'd0);
    drive(16'h0003, 16'h0000, 1'b1); tick();
    chk("to_next", 32'(select), 32'd1);
    chk("to_clear", 32'(timeout_err), 32'd0);
`else
    for (int c = 0; c < 80; c++) begin
      drive(16'h0003, 16'h0000, 1'b1); tick();
    end
    chk("hold_enable", 32'(enable), 32'd1);
    chk("hold_select", 32'(select), 32'd0);
`endif

    // randomized traffic
    do_reset();
    for (int c = 0; c < 3000; c++) begin
      if (c % 1000 == 999) do_reset();
      case ((c / 250) % 3)
        0:       r = N'($urandom) & N'($urandom) & N'($urandom);
        1:       r = N'($urandom);
        default: r = (N'(1) << $urandom_range(0, N - 1)) | (N'(1) << $urandom_range(0, N - 1));
      endcase
      e = N'($urandom) & N'($urandom);
      drive(r, e, $urandom_range(0, 3) != 0);
      tick();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
